// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - fixed-latency load/store sequencer between a pipeline and a registered data memory
// Each request takes exactly three edges: strobe cycle, memory commit/read cycle, response cycle.
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RD_A,
        RD_B
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_write_data;
    logic [CNT_W-1:0]  r_rd_count;
    logic [CNT_W-1:0]  r_wr_count;
    logic              w_idle;

    assign w_idle = (r_state == IDLE);

    // Address and write data are only loaded on a handshake, so they stay put
    // through the memory's delayed commit edge and across idle periods.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_rd_count   <= '0;
            r_wr_count   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_alu_result <= req_addr;
                        if (req_we) begin
                            r_write_data <= req_wdata;
                            r_mem_write  <= 1'b1;
                            r_state      <= WR_A;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= RD_A;
                        end
                    end
                end
                WR_A: r_state <= WR_B;
                WR_B: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b1;
                    r_wr_count   <= r_wr_count + CNT_ONE;
                end
                RD_A: r_state <= RD_B;
                RD_B: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= read_data;
                    r_rd_count   <= r_rd_count + CNT_ONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = w_idle;
    assign busy       = !w_idle;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign MemRead    = r_mem_read;
    assign MemWrite   = r_mem_write;
    assign alu_result = r_alu_result;
    assign write_data = r_write_data;
    assign rd_count   = r_rd_count;
    assign wr_count   = r_wr_count;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter CNT_W, default 16, transaction counter width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-006 req_valid  input  1  pipeline presents a memory request.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_W  request address.
REQ-010 req_wdata  input  DATA_W  store data.
REQ-011 resp_valid  output  1  one-cycle pulse: request completed.
REQ-012 resp_rdata  output  DATA_W  load result, valid while resp_valid=1 and held until the next load completes.
REQ-013 MemRead  output  1  read strobe to the data memory stage.
REQ-014 MemWrite  output  1  write strobe to the data memory stage.
REQ-015 alu_result  output  ADDR_W  memory address bus.
REQ-016 write_data  output  DATA_W  memory write data bus.
REQ-017 read_data  input  DATA_W  registered memory read data.
REQ-018 busy  output  1  high whenever the state is not IDLE.
REQ-019 rd_count / wr_count  output  CNT_W each  completed load / store counts.

Function
REQ-020 The FSM SHALL have exactly five states: IDLE, WR_A, WR_B, RD_A, RD_B.
REQ-021 req_ready SHALL equal (state==IDLE); the handshake completes on an edge where req_valid and req_ready are both 1.
REQ-022 On handshake, the block SHALL latch req_addr to alu_result and req_wdata to write_data (store only), then go to WR_A if req_we=1, otherwise to RD_A.
REQ-023 All memory-side outputs SHALL be registered; MemWrite=1 only in WR_A and MemRead=1 only in RD_A.
REQ-024 WR_A SHALL always go to WR_B; WR_B SHALL always go to IDLE, with resp_valid=1 in the following cycle.
REQ-025 alu_result and write_data SHALL hold stable from the handshake edge E0 through edge E2, because the memory commits at E2 using its delayed MemWrite.
REQ-026 RD_A SHALL always go to RD_B; at the RD_B exit edge, resp_rdata SHALL take read_data, resp_valid=1 for one cycle, and the state SHALL return to IDLE.
REQ-027 Latency SHALL be fixed: for a handshake at edge E0, resp_valid is high in the cycle after E2, for both loads and stores.
REQ-028 A new request SHALL be acceptable in the same cycle that resp_valid=1 (back-to-back throughput: one request per 3 cycles).
REQ-029 A load accepted at or after the completion edge of a store to the same address SHALL return the newly written data (no read-after-write hazard).
REQ-030 req_valid while busy=1 SHALL be ignored; the request inputs SHALL not be sampled.
REQ-031 In IDLE, alu_result and write_data SHALL keep their last values, and MemRead=MemWrite=0.
REQ-032 wr_count SHALL increment at each store completion, and rd_count at each load completion; both wrap modulo 2^CNT_W.

Reset
REQ-033 With reset=0, the block SHALL immediately set: state=IDLE; MemRead, MemWrite, resp_valid, and busy to 0; alu_result, write_data, resp_rdata, rd_count, and wr_count to 0; req_ready=1.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no resp_valid and no counter update.
REQ-035 After reset deasserts, the block SHALL be able to accept a request on the first rising edge.

Verification
REQ-036 Store addr 0x10 data 0xA5 -> MemWrite high for exactly 1 cycle; addr/data held 3 cycles; resp_valid after E2; wr_count=1.
REQ-037 Store 0x10←0xA5, then immediately load 0x10 -> resp_rdata=0xA5; rd_count=1.
REQ-038 Load from a never-written address 0xFF -> resp_rdata=0x00.
REQ-039 req_valid held high continuously with alternating stores/loads to 0x00..0x03 -> one handshake per 3 cycles; none dropped or duplicated; data correct.
REQ-040 reset=0 asserted in WR_B -> outputs immediately at reset values; no resp_valid; wr_count=0.
REQ-041 wr_count preset via 2^CNT_W stores (CNT_W=4 build: 16 stores) -> counter wraps to 0.
